// File: rtl/round_judge_pkg.sv
// Shared codes for the rock-paper-scissors round judge: move encodings,
// matchresult codes (as decoded by the score-update block) and FSM states.
package round_judge_pkg;

   localparam logic [1:0] MOVE_ILLEGAL  = 2'b00;
   localparam logic [1:0] MOVE_ROCK     = 2'b01;
   localparam logic [1:0] MOVE_PAPER    = 2'b10;
   localparam logic [1:0] MOVE_SCISSORS = 2'b11;

   localparam logic [1:0] RES_NONE  = 2'b00;
   localparam logic [1:0] RES_DRAW  = 2'b01;
   localparam logic [1:0] RES_P1WIN = 2'b10;
   localparam logic [1:0] RES_P2WIN = 2'b11;

   typedef enum logic [2:0] {
      ST_COLLECT,
      ST_HALF,
      ST_JUDGE,
      ST_FORFEIT,
      ST_REPORT,
      ST_GAME_OVER
   } state_t;

endpackage

// File: rtl/round_judge_rps_compare.sv
// Combinational rock-paper-scissors judge: result is from player A's point of view
// (P1WIN means move_a wins). Inputs are assumed legal moves.
module rps_compare
   import round_judge_pkg::*;
(
   input  logic [1:0] move_a,
   input  logic [1:0] move_b,
   output logic [1:0] result
);

   always_comb begin
      result = RES_P2WIN;
      if (move_a == move_b) begin
         result = RES_DRAW;
      end else if ((move_a == MOVE_ROCK     && move_b == MOVE_SCISSORS) ||
                   (move_a == MOVE_PAPER    && move_b == MOVE_ROCK)     ||
                   (move_a == MOVE_SCISSORS && move_b == MOVE_PAPER)) begin
         result = RES_P1WIN;
      end
   end

endmodule

// File: rtl/round_judge.sv
// Round judge: collects one move per player via valid/ready, judges or forfeits the
// round, and reports a registered matchresult with a one-cycle round_done strobe.
module round_judge
   import round_judge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int MAX_ROUNDS     = 9
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] p1_move,
   input  logic       p1_valid,
   output logic       p1_ready,
   input  logic [1:0] p2_move,
   input  logic       p2_valid,
   output logic       p2_ready,
   output logic [1:0] matchresult,
   output logic       round_done,
   output logic [3:0] round_num,
   output logic       illegal_move,
   output logic       game_over
);

   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] ROUNDS_END = 4'(MAX_ROUNDS);

   state_t     state;
   logic       p1_cap, p2_cap;
   logic [1:0] p1_q, p2_q;
   logic [7:0] tmo_cnt;
   logic [1:0] judged;
   logic       collecting;
   logic       p1_take, p2_take, p1_bad, p2_bad;

   // Handshake: a move transfers on a rising edge where valid & ready are both high.
   // Ready is high only while collecting and the player has not yet been captured;
   // an offered 00 transfers nothing and only raises illegal_move.
   assign collecting = (state == ST_COLLECT) || (state == ST_HALF);
   assign p1_ready   = ~reset & collecting & ~p1_cap;
   assign p2_ready   = ~reset & collecting & ~p2_cap;

   assign p1_take = p1_valid & p1_ready & (p1_move != MOVE_ILLEGAL);
   assign p2_take = p2_valid & p2_ready & (p2_move != MOVE_ILLEGAL);
   assign p1_bad  = p1_valid & p1_ready & (p1_move == MOVE_ILLEGAL);
   assign p2_bad  = p2_valid & p2_ready & (p2_move == MOVE_ILLEGAL);

   rps_compare u_compare (
      .move_a (p1_q),
      .move_b (p2_q),
      .result (judged)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_COLLECT;
         p1_cap       <= 1'b0;
         p2_cap       <= 1'b0;
         p1_q         <= MOVE_ILLEGAL;
         p2_q         <= MOVE_ILLEGAL;
         tmo_cnt      <= 8'd0;
         matchresult  <= RES_NONE;
         round_done   <= 1'b0;
         round_num    <= 4'd0;
         illegal_move <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         round_done   <= 1'b0;
         illegal_move <= p1_bad | p2_bad;
         if (p1_take) begin
            p1_cap <= 1'b1;
            p1_q   <= p1_move;
         end
         if (p2_take) begin
            p2_cap <= 1'b1;
            p2_q   <= p2_move;
         end
         case (state)
            ST_COLLECT: begin
               if (p1_take && p2_take) begin
                  state <= ST_JUDGE;
               end else if (p1_take || p2_take) begin
                  state   <= ST_HALF;
                  tmo_cnt <= 8'd0;
               end
            end
            ST_HALF: begin
               tmo_cnt <= tmo_cnt + 8'd1;
               // A late capture on the expiry edge still wins over the forfeit.
               if (p1_take || p2_take) begin
                  state <= ST_JUDGE;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= ST_FORFEIT;
               end
            end
            ST_JUDGE: begin
               matchresult <= judged;
               round_done  <= 1'b1;
               state       <= ST_REPORT;
            end
            ST_FORFEIT: begin
               matchresult <= p1_cap ? RES_P1WIN : RES_P2WIN;
               round_done  <= 1'b1;
               state       <= ST_REPORT;
            end
            ST_REPORT: begin
               round_num <= round_num + 4'd1;
               p1_cap    <= 1'b0;
               p2_cap    <= 1'b0;
               if (round_num + 4'd1 == ROUNDS_END) begin
                  state     <= ST_GAME_OVER;
                  game_over <= 1'b1;
               end else begin
                  state <= ST_COLLECT;
               end
            end
            ST_GAME_OVER: begin
               game_over <= 1'b1;
            end
            default: begin
               state <= ST_COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_round_judge.sv
// Directed and randomized rounds for round_judge, checked against a round-level
// model that predicts winner, strobe timing and round count from the game rules.
module tb_round_judge;
   import round_judge_pkg::*;

   localparam int T  = 15;
   localparam int MR = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] p1_move = 2'b00, p2_move = 2'b00;
   logic       p1_valid = 1'b0, p2_valid = 1'b0;
   logic       p1_ready, p2_ready;
   logic [1:0] matchresult;
   logic       round_done;
   logic [3:0] round_num;
   logic       illegal_move;
   logic       game_over;

   int         total = 0;
   int         bad = 0;
   int         exp_rn = 0;
   logic [1:0] exp_mr = RES_NONE;

   round_judge #(.TIMEOUT_CYCLES(T), .MAX_ROUNDS(MR)) dut (
      .clk          (clk),
      .reset        (reset),
      .p1_move      (p1_move),
      .p1_valid     (p1_valid),
      .p1_ready     (p1_ready),
      .p2_move      (p2_move),
      .p2_valid     (p2_valid),
      .p2_ready     (p2_ready),
      .matchresult  (matchresult),
      .round_done   (round_done),
      .round_num    (round_num),
      .illegal_move (illegal_move),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      assert (got === expv) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   // Moves 1..3 form a cycle in which each beats the one numerically below it (mod 3).
   function automatic logic [1:0] judge(input int a, input int b);
      if (a == b) return RES_DRAW;
      if ((a - b + 3) % 3 == 1) return RES_P1WIN;
      return RES_P2WIN;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      p1_valid = 1'b0;
      p2_valid = 1'b0;
      #1;
      check("rst_matchresult", matchresult, RES_NONE);
      check("rst_round_done", round_done, 0);
      check("rst_round_num", round_num, 0);
      check("rst_illegal", illegal_move, 0);
      check("rst_game_over", game_over, 0);
      check("rst_p1_ready", p1_ready, 0);
      check("rst_p2_ready", p2_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_rn = 0;
      exp_mr = RES_NONE;
      #1;
      check("rel_p1_ready", p1_ready, 1);
      check("rel_p2_ready", p2_ready, 1);
   endtask

   // d1/d2: cycle (relative to call) at which a player starts offering; -1 = silent.
   task automatic play_round(input int m1, input int d1, input int m2, input int d2);
      int         a, b, exp_edge, rd_cnt, rd_edge, ill;
      bit         forfeit, p1_done, p2_done;
      logic [1:0] exp_res, rd_mr;
      b = 0;
      if (d1 < 0) begin
         forfeit = 1'b1; a = d2 + 1; exp_res = RES_P2WIN;
      end else if (d2 < 0) begin
         forfeit = 1'b1; a = d1 + 1; exp_res = RES_P1WIN;
      end else begin
         forfeit = 1'b0; a = 0;
         b = ((d1 > d2) ? d1 : d2) + 1;
         exp_res = judge(m1, m2);
      end
      exp_edge = forfeit ? a + T + 1 : b + 1;
      p1_done = 1'b0; p2_done = 1'b0;
      rd_cnt = 0; rd_edge = -1; rd_mr = RES_NONE; ill = 0;
      for (int e = 0; e <= exp_edge + 1; e++) begin
         if (e > 0) begin
            if (round_done) begin
               rd_cnt++;
               rd_edge = e;
               rd_mr = matchresult;
            end
            if (illegal_move) ill++;
         end
         if (e == exp_edge + 1) break;
         p1_move  = 2'(m1);
         p2_move  = 2'(m2);
         p1_valid = (d1 >= 0) && (e >= d1) && !p1_done;
         p2_valid = (d2 >= 0) && (e >= d2) && !p2_done;
         if (p1_valid && p1_ready) p1_done = 1'b1;
         if (p2_valid && p2_ready) p2_done = 1'b1;
         @(posedge clk);
         #1;
      end
      p1_valid = 1'b0;
      p2_valid = 1'b0;
      exp_rn++;
      exp_mr = exp_res;
      check("rd_count", rd_cnt, 1);
      check("rd_edge", rd_edge, exp_edge);
      check("rd_result", rd_mr, exp_res);
      check("held_result", matchresult, exp_mr);
      check("round_num", round_num, exp_rn);
      check("no_illegal", ill, 0);
      check("game_over", game_over, (exp_rn == MR) ? 1 : 0);
      check("p1_ready_after", p1_ready, (exp_rn == MR) ? 0 : 1);
   endtask

   initial begin
      int m1, m2, d1, d2, gap;

      do_reset();
      play_round(1, 0, 3, 0);
      play_round(2, 3, 2, 7);
      play_round(1, -1, 3, 0);

      for (int i = 0; i < 5; i++) begin
         p1_move = MOVE_ROCK; p2_move = MOVE_PAPER;
         p1_valid = 1'b1; p2_valid = 1'b1;
         #1;
         check("go_p1_ready", p1_ready, 0);
         check("go_p2_ready", p2_ready, 0);
         @(posedge clk);
         #1;
         check("go_round_done", round_done, 0);
      end
      p1_valid = 1'b0; p2_valid = 1'b0;
      check("go_round_num", round_num, MR);
      check("go_result_hold", matchresult, exp_mr);
      check("go_flag", game_over, 1);

      do_reset();
      play_round(2, 15, 3, 0);

      p1_move = MOVE_ILLEGAL; p1_valid = 1'b1;
      #1;
      check("ill_p1_ready_pre", p1_ready, 1);
      @(posedge clk);
      #1;
      p1_valid = 1'b0;
      check("ill_p1_pulse", illegal_move, 1);
      check("ill_p1_ready_post", p1_ready, 1);
      @(posedge clk);
      #1;
      check("ill_p1_end", illegal_move, 0);
      p1_move = MOVE_ILLEGAL; p2_move = MOVE_ILLEGAL;
      p1_valid = 1'b1; p2_valid = 1'b1;
      @(posedge clk);
      #1;
      p1_valid = 1'b0; p2_valid = 1'b0;
      check("ill_both_pulse", illegal_move, 1);
      check("ill_both_p2_ready", p2_ready, 1);
      @(posedge clk);
      #1;
      check("ill_both_end", illegal_move, 0);
      play_round(1, 0, 2, 0);

      do_reset();
      p1_move = MOVE_ROCK; p1_valid = 1'b1;
      @(posedge clk);
      #1;
      p1_valid = 1'b0;
      check("half_p1_ready", p1_ready, 0);
      check("half_p2_ready", p2_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < T + 5; i++) begin
         @(posedge clk);
         #1;
         check("mid_rst_no_done", round_done, 0);
      end
      check("mid_rst_result", matchresult, RES_NONE);
      check("mid_rst_round_num", round_num, 0);
      play_round(1, 0, 1, 0);

      for (int r = 0; r < 30; r++) begin
         if (exp_rn == MR) do_reset();
         m1 = $urandom_range(1, 3);
         m2 = $urandom_range(1, 3);
         d1 = $urandom_range(0, 6);
         if ($urandom_range(0, 3) == 0) begin
            d2 = d1;
            if ($urandom_range(0, 1) == 1) d1 = -1;
            else d2 = -1;
         end else begin
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(T - 1, T) : $urandom_range(0, T);
            d2 = d1 + gap;
            if ($urandom_range(0, 1) == 1) begin
               d2 = d1;
               d1 = d1 + gap;
            end
         end
         play_round(m1, d1, m2, d2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
